id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the register file.
- Captures the two register-file read operands, register addresses, immediate, PC values and decoded control, and presents them to the execute stage one cycle later.
- The register file writes on the rising edge and reads combinationally, so a same-cycle writeback would otherwise be lost. This block bypasses writeback data into the captured operands to cover that case.
- Supports stall (hold) and flush (bubble insertion) driven by the hazard unit.

Parameters:
- ADDRESS_WIDTH, 5, register address width.
- DATA_WIDTH, 32, operand, immediate and PC width.

Ports:
- CLK  in  1  clock, rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- StallE  in  1  hold all E registers.
- FlushE  in  1  load a bubble.
- ValidD  in  1  decode slot holds a real instruction.
- RD1D, RD2D  in  DATA_WIDTH  register-file read data.
- Rs1D, Rs2D, RdD  in  ADDRESS_WIDTH  source and destination addresses.
- ImmExtD, PCD, PCPlus4D  in  DATA_WIDTH  immediate, PC, PC+4.
- CtrlD  in  ctrl_t  packed control: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[3:0], ALUSrc.
- RegWriteW  in  1  writeback enable, the same signal as the register-file write enable.
- RdW  in  ADDRESS_WIDTH  writeback address.
- ResultW  in  DATA_WIDTH  writeback data.
- ValidE  out  1  execute slot valid.
- RD1E, RD2E  out  DATA_WIDTH  captured, bypassed operands.
- Rs1E, Rs2E, RdE  out  ADDRESS_WIDTH.
- ImmExtE, PCE, PCPlus4E  out  DATA_WIDTH.
- CtrlE  out  ctrl_t.

Behaviour:
- All outputs are registered; there is no combinational path from any input to any output. Latency is 1 cycle.
- Reset: RST_N low immediately and asynchronously forces every output to 0, including ValidE and all CtrlE fields. Release is synchronous-safe; the first capture happens on the first rising edge with RST_N high.
- Priority at each rising edge: reset > FlushE > StallE > load.
- Load (FlushE=0, StallE=0):
  - Every E register takes its D input.
  - RD1E takes ResultW if hit1 = RegWriteW && RdW!=0 && RdW==Rs1D; otherwise RD1D.
  - RD2E follows the same rule using Rs2D.
- Flush (FlushE=1, regardless of StallE): every output register, data included, loads 0. The result is ValidE=0, CtrlE all-zero (RegWrite=0, MemWrite=0, Jump=0, Branch=0) and RdE=0.
- Stall (StallE=1, FlushE=0):
  - All registers hold, except the held-operand refresh below.
  - Refresh: if RegWriteW && RdW!=0 && RdW==Rs1E, RD1E loads ResultW. Same for RD2E using Rs2E.
  - Purpose: a stalled instruction must not keep a stale operand while the older producer retires.
- x0:
  - RdW==0 never triggers a bypass, because a register-file write to x0 is ignored.
  - Rs==0 with RegWriteW && RdW==0 therefore still captures RD1D/RD2D, which is 0.
- Both sources equal RdW: both operands bypass in the same cycle.
- ValidD=0 on load: ValidE=0. Control is still captured as presented; decode is required to zero CtrlD for invalid slots.
- Widths: all datapath fields are DATA_WIDTH with no extension or truncation. Address comparisons are ADDRESS_WIDTH-bit equality.
- Reset asserted mid-stall or mid-flush: reset wins immediately; the held contents are discarded.

Decomposition:
- Package cpu_pkg:
  - ctrl_t packed struct, field order as listed under Ports.
  - result_src_e: ALU=2'b00, MEM=2'b01, PC4=2'b10.
  - alu_ctrl_e: 4-bit ALU operation encodings.
  - CTRL_NOP constant, all zero.
- Sub-module operand_bypass: combinational; inputs en, rd, rs, result, rf_data; output the selected operand.
  - Instantiated four times: RD1/RD2 on the load path (Rs1D/Rs2D), and RD1/RD2 on the refresh path (Rs1E/Rs2E).

Test Plan:
- Reset and load: RST_N low mid-cycle → all outputs 0 immediately. Release, then drive RD1D=0x11, RD2D=0x22, Rs1D=1, Rs2D=2, RdD=3, PCD=0x100, ValidD=1 → next edge RD1E=0x11, RD2E=0x22, RdE=3, PCE=0x100, ValidE=1.
- WB bypass: Rs1D=5, RD1D=0xAAAA, RegWriteW=1, RdW=5, ResultW=0x1234 → RD1E=0x1234. Same stimulus with RdW=0 and Rs1D=0 → RD1E=RD1D.
- Dual bypass: Rs1D=Rs2D=7, RdW=7, ResultW=0xBEEF, RegWriteW=1 → RD1E=RD2E=0xBEEF.
- Stall hold and refresh:
  - Load Rs2E=9, RD2E=0x5, then StallE=1 for 3 cycles with no WB → all outputs unchanged.
  - On the 2nd stall cycle pulse RegWriteW=1, RdW=9, ResultW=0x77 → RD2E=0x77 and RD1E unchanged.
- Flush priority: StallE=1 and FlushE=1 with valid E contents → next edge ValidE=0, CtrlE=CTRL_NOP, RdE=0, RD1E=0.
- Back-to-back stream: 8 consecutive loads with incrementing PCD (0x0,0x4,…) and StallE/FlushE=0 → PCE follows PCD with exactly 1-cycle lag and no drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode/execute types: packed control word, its field encodings and the bubble value.
package cpu_pkg;

    typedef enum logic [1:0] {
        ALU = 2'b00,
        MEM = 2'b01,
        PC4 = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    // Fields kept as raw bit vectors so any decode value passes through untouched.
    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [3:0] ALUControl;
        logic       ALUSrc;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX register.
interface id_ex_stage_reg_if
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) ();
    logic                     StallE;
    logic                     FlushE;
    logic                     ValidD;
    logic [DATA_WIDTH-1:0]    RD1D;
    logic [DATA_WIDTH-1:0]    RD2D;
    logic [ADDRESS_WIDTH-1:0] Rs1D;
    logic [ADDRESS_WIDTH-1:0] Rs2D;
    logic [ADDRESS_WIDTH-1:0] RdD;
    logic [DATA_WIDTH-1:0]    ImmExtD;
    logic [DATA_WIDTH-1:0]    PCD;
    logic [DATA_WIDTH-1:0]    PCPlus4D;
    ctrl_t                    CtrlD;
    logic                     RegWriteW;
    logic [ADDRESS_WIDTH-1:0] RdW;
    logic [DATA_WIDTH-1:0]    ResultW;

    logic                     ValidE;
    logic [DATA_WIDTH-1:0]    RD1E;
    logic [DATA_WIDTH-1:0]    RD2E;
    logic [ADDRESS_WIDTH-1:0] Rs1E;
    logic [ADDRESS_WIDTH-1:0] Rs2E;
    logic [ADDRESS_WIDTH-1:0] RdE;
    logic [DATA_WIDTH-1:0]    ImmExtE;
    logic [DATA_WIDTH-1:0]    PCE;
    logic [DATA_WIDTH-1:0]    PCPlus4E;
    ctrl_t                    CtrlE;

    modport slave (
        input  StallE, FlushE, ValidD, RD1D, RD2D, Rs1D, Rs2D, RdD,
               ImmExtD, PCD, PCPlus4D, CtrlD, RegWriteW, RdW, ResultW,
        output ValidE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E, CtrlE
    );

    modport master (
        output StallE, FlushE, ValidD, RD1D, RD2D, Rs1D, Rs2D, RdD,
               ImmExtD, PCD, PCPlus4D, CtrlD, RegWriteW, RdW, ResultW,
        input  ValidE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E, CtrlE
    );
endinterface

// File: rtl/operand_bypass.sv
// Selects writeback data over register-file data when the writeback targets rs (x0 never matches).
module operand_bypass #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic [ADDRESS_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0]    result,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    output logic [DATA_WIDTH-1:0]    operand
);
    assign operand = (en && (rd != '0) && (rd == rs)) ? result : rf_data;
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with same-cycle writeback bypass; 1-cycle latency, fully registered outputs.
// Priority reset > flush > stall > load; a stalled slot still picks up writebacks to its sources.
module id_ex_stage_reg
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    id_ex_stage_reg_if.slave   stage_if
);
    logic                     valid_q,  valid_d;
    logic [DATA_WIDTH-1:0]    rd1_q,    rd1_d;
    logic [DATA_WIDTH-1:0]    rd2_q,    rd2_d;
    logic [ADDRESS_WIDTH-1:0] rs1_q,    rs1_d;
    logic [ADDRESS_WIDTH-1:0] rs2_q,    rs2_d;
    logic [ADDRESS_WIDTH-1:0] rd_q,     rd_d;
    logic [DATA_WIDTH-1:0]    imm_q,    imm_d;
    logic [DATA_WIDTH-1:0]    pc_q,     pc_d;
    logic [DATA_WIDTH-1:0]    pc4_q,    pc4_d;
    ctrl_t                    ctrl_q,   ctrl_d;

    logic [DATA_WIDTH-1:0] load_rd1, load_rd2, hold_rd1, hold_rd2;

    operand_bypass #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_load_rd1 (
        .en(stage_if.RegWriteW), .rd(stage_if.RdW), .rs(stage_if.Rs1D),
        .result(stage_if.ResultW), .rf_data(stage_if.RD1D), .operand(load_rd1)
    );
    operand_bypass #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_load_rd2 (
        .en(stage_if.RegWriteW), .rd(stage_if.RdW), .rs(stage_if.Rs2D),
        .result(stage_if.ResultW), .rf_data(stage_if.RD2D), .operand(load_rd2)
    );
    // Held operands are refreshed against the captured source addresses.
    operand_bypass #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_hold_rd1 (
        .en(stage_if.RegWriteW), .rd(stage_if.RdW), .rs(rs1_q),
        .result(stage_if.ResultW), .rf_data(rd1_q), .operand(hold_rd1)
    );
    operand_bypass #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_hold_rd2 (
        .en(stage_if.RegWriteW), .rd(stage_if.RdW), .rs(rs2_q),
        .result(stage_if.ResultW), .rf_data(rd2_q), .operand(hold_rd2)
    );

    always_comb begin
        valid_d = valid_q;
        rd1_d   = hold_rd1;
        rd2_d   = hold_rd2;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        ctrl_d  = ctrl_q;
        if (stage_if.FlushE) begin
            valid_d = 1'b0;
            rd1_d   = '0;
            rd2_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            imm_d   = '0;
            pc_d    = '0;
            pc4_d   = '0;
            ctrl_d  = CTRL_NOP;
        end else if (!stage_if.StallE) begin
            valid_d = stage_if.ValidD;
            rd1_d   = load_rd1;
            rd2_d   = load_rd2;
            rs1_d   = stage_if.Rs1D;
            rs2_d   = stage_if.Rs2D;
            rd_d    = stage_if.RdD;
            imm_d   = stage_if.ImmExtD;
            pc_d    = stage_if.PCD;
            pc4_d   = stage_if.PCPlus4D;
            ctrl_d  = stage_if.CtrlD;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            valid_q <= valid_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign stage_if.ValidE   = valid_q;
    assign stage_if.RD1E     = rd1_q;
    assign stage_if.RD2E     = rd2_q;
    assign stage_if.Rs1E     = rs1_q;
    assign stage_if.Rs2E     = rs2_q;
    assign stage_if.RdE      = rd_q;
    assign stage_if.ImmExtE  = imm_q;
    assign stage_if.PCE      = pc_q;
    assign stage_if.PCPlus4E = pc4_q;
    assign stage_if.CtrlE    = ctrl_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, async-reset checks, then random traffic vs. a reference model.
module tb_id_ex_stage_reg;
    import cpu_pkg::*;

    logic CLK;
    logic RST_N;
    int   n_checks = 0;
    int   n_errors = 0;

    id_ex_stage_reg_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

    id_ex_stage_reg #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .stage_if (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [10:0] ctrl;
    } e_t;

    typedef struct {
        logic        stall, flush, valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, pc;
        logic [10:0] ctrl;
        logic        rw_w;
        logic [4:0]  rd_w;
        logic [31:0] res_w;
        logic        e_valid;
        logic [31:0] e_rd1, e_rd2;
        logic [4:0]  e_rd;
        logic [31:0] e_pc;
        logic [10:0] e_ctrl;
    } vec_t;

    vec_t vecs[12];
    e_t   exp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic e_t act_state();
        e_t a;
        a.valid = bus.ValidE;  a.rd1 = bus.RD1E;     a.rd2  = bus.RD2E;
        a.rs1   = bus.Rs1E;    a.rs2 = bus.Rs2E;     a.rd   = bus.RdE;
        a.imm   = bus.ImmExtE; a.pc  = bus.PCE;      a.pc4  = bus.PCPlus4E;
        a.ctrl  = bus.CtrlE;
        return a;
    endfunction

    task automatic chk_state(input string name);
        e_t a;
        a = act_state();
        n_checks++;
        if (a !== exp_e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, a, exp_e);
        end
    endtask

    // A writeback reaches source rs unless it is disabled or targets x0.
    function automatic logic wb_hits(input logic [4:0] rs);
        return bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == rs);
    endfunction

    function automatic e_t model_next(input e_t cur);
        e_t n;
        n = cur;
        if (bus.FlushE) begin
            n = '0;
        end else if (bus.StallE) begin
            if (wb_hits(cur.rs1)) n.rd1 = bus.ResultW;
            if (wb_hits(cur.rs2)) n.rd2 = bus.ResultW;
        end else begin
            n.valid = bus.ValidD;
            n.rd1   = wb_hits(bus.Rs1D) ? bus.ResultW : bus.RD1D;
            n.rd2   = wb_hits(bus.Rs2D) ? bus.ResultW : bus.RD2D;
            n.rs1   = bus.Rs1D;   n.rs2 = bus.Rs2D;  n.rd  = bus.RdD;
            n.imm   = bus.ImmExtD; n.pc = bus.PCD;    n.pc4 = bus.PCPlus4D;
            n.ctrl  = bus.CtrlD;
        end
        return n;
    endfunction

    task automatic tick(input string name);
        exp_e = model_next(exp_e);
        @(posedge CLK);
        #1;
        chk_state(name);
    endtask

    task automatic randomize_inputs();
        bus.StallE    = ($urandom_range(0, 3) == 0);
        bus.FlushE    = ($urandom_range(0, 7) == 0);
        bus.ValidD    = 1'($urandom_range(0, 1));
        bus.RD1D      = $urandom;
        bus.RD2D      = $urandom;
        bus.Rs1D      = 5'($urandom_range(0, 7));
        bus.Rs2D      = 5'($urandom_range(0, 7));
        bus.RdD       = 5'($urandom_range(0, 31));
        bus.ImmExtD   = $urandom;
        bus.PCD       = $urandom;
        bus.PCPlus4D  = bus.PCD + 32'd4;
        bus.CtrlD     = ctrl_t'(11'($urandom));
        bus.RegWriteW = 1'($urandom_range(0, 1));
        bus.RdW       = 5'($urandom_range(0, 7));
        bus.ResultW   = $urandom;
    endtask

    initial begin
        //        stall flush valid rs1    rs2    rd     rd1          rd2          pc           ctrl     rw    rdW    resW         | valid rd1          rd2          rd     pc           ctrl
        vecs[0]  = '{1'b0,1'b0,1'b1, 5'd1, 5'd2, 5'd3, 32'h11,      32'h22,      32'h100,     11'h5A5, 1'b0, 5'd0,  32'h0,       1'b1, 32'h11,      32'h22,      5'd3,  32'h100,     11'h5A5};
        vecs[1]  = '{1'b0,1'b0,1'b1, 5'd5, 5'd6, 5'd4, 32'hAAAA,    32'hBBBB,    32'h104,     11'h123, 1'b1, 5'd5,  32'h1234,    1'b1, 32'h1234,    32'hBBBB,    5'd4,  32'h104,     11'h123};
        vecs[2]  = '{1'b0,1'b0,1'b1, 5'd0, 5'd0, 5'd4, 32'hAAAA,    32'h0,       32'h108,     11'h0F0, 1'b1, 5'd0,  32'h1234,    1'b1, 32'hAAAA,    32'h0,       5'd4,  32'h108,     11'h0F0};
        vecs[3]  = '{1'b0,1'b0,1'b1, 5'd7, 5'd7, 5'd7, 32'h1,       32'h2,       32'h10C,     11'h7FF, 1'b1, 5'd7,  32'hBEEF,    1'b1, 32'hBEEF,    32'hBEEF,    5'd7,  32'h10C,     11'h7FF};
        vecs[4]  = '{1'b0,1'b0,1'b1, 5'd8, 5'd8, 5'd2, 32'h31,      32'h32,      32'h110,     11'h001, 1'b0, 5'd8,  32'hDEAD,    1'b1, 32'h31,      32'h32,      5'd2,  32'h110,     11'h001};
        vecs[5]  = '{1'b0,1'b0,1'b1, 5'd10,5'd9, 5'd12,32'h66,      32'h5,       32'h200,     11'h3C3, 1'b0, 5'd0,  32'h0,       1'b1, 32'h66,      32'h5,       5'd12, 32'h200,     11'h3C3};
        vecs[6]  = '{1'b1,1'b0,1'b0, 5'd9, 5'd10,5'd1, 32'h999,     32'h888,     32'h300,     11'h111, 1'b0, 5'd9,  32'h55,      1'b1, 32'h66,      32'h5,       5'd12, 32'h200,     11'h3C3};
        vecs[7]  = '{1'b1,1'b0,1'b0, 5'd11,5'd11,5'd1, 32'h999,     32'h888,     32'h300,     11'h111, 1'b1, 5'd9,  32'h77,      1'b1, 32'h66,      32'h77,      5'd12, 32'h200,     11'h3C3};
        vecs[8]  = '{1'b1,1'b0,1'b1, 5'd1, 5'd1, 5'd1, 32'h999,     32'h888,     32'h304,     11'h222, 1'b1, 5'd0,  32'h99,      1'b1, 32'h66,      32'h77,      5'd12, 32'h200,     11'h3C3};
        vecs[9]  = '{1'b1,1'b1,1'b1, 5'd1, 5'd2, 5'd3, 32'h123,     32'h456,     32'h400,     11'h7FF, 1'b1, 5'd10, 32'h44,      1'b0, 32'h0,       32'h0,       5'd0,  32'h0,       11'h000};
        vecs[10] = '{1'b0,1'b0,1'b0, 5'd3, 5'd4, 5'd5, 32'hC,       32'hD,       32'h500,     11'h000, 1'b0, 5'd0,  32'h0,       1'b0, 32'hC,       32'hD,       5'd5,  32'h500,     11'h000};
        vecs[11] = '{1'b1,1'b0,1'b1, 5'd0, 5'd0, 5'd0, 32'h0,       32'h0,       32'h0,       11'h000, 1'b1, 5'd3,  32'hFACE,    1'b0, 32'hFACE,    32'hD,       5'd5,  32'h500,     11'h000};

        RST_N = 1'b1;
        bus.StallE = 1'b0; bus.FlushE = 1'b0; bus.ValidD = 1'b0;
        bus.RD1D = '0; bus.RD2D = '0; bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
        bus.ImmExtD = '0; bus.PCD = '0; bus.PCPlus4D = '0; bus.CtrlD = CTRL_NOP;
        bus.RegWriteW = 1'b0; bus.RdW = '0; bus.ResultW = '0;

        #2 RST_N = 1'b0;
        #1;
        exp_e = '0;
        chk_state("reset_async_zero");
        #9 RST_N = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.StallE    = vecs[i].stall;
            bus.FlushE    = vecs[i].flush;
            bus.ValidD    = vecs[i].valid;
            bus.Rs1D      = vecs[i].rs1;
            bus.Rs2D      = vecs[i].rs2;
            bus.RdD       = vecs[i].rd;
            bus.RD1D      = vecs[i].rd1;
            bus.RD2D      = vecs[i].rd2;
            bus.PCD       = vecs[i].pc;
            bus.PCPlus4D  = vecs[i].pc + 32'd4;
            bus.ImmExtD   = vecs[i].pc ^ 32'hF0;
            bus.CtrlD     = ctrl_t'(vecs[i].ctrl);
            bus.RegWriteW = vecs[i].rw_w;
            bus.RdW       = vecs[i].rd_w;
            bus.ResultW   = vecs[i].res_w;
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(bus.ValidE), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_rd1", i),   bus.RD1E,        vecs[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i),   bus.RD2E,        vecs[i].e_rd2);
            chk($sformatf("vec%0d_rd", i),    32'(bus.RdE),    32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_pc", i),    bus.PCE,         vecs[i].e_pc);
            chk($sformatf("vec%0d_ctrl", i),  32'(bus.CtrlE),  32'(vecs[i].e_ctrl));
        end

        // Resynchronise the model with the DUT through a flush.
        bus.FlushE = 1'b1;
        exp_e = '0;
        tick("flush_resync");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if (i == 200) begin
                bus.StallE = 1'b1;
                bus.FlushE = 1'b0;
                #1 RST_N = 1'b0;
                #1;
                exp_e = '0;
                chk_state("reset_mid_stall");
                RST_N = 1'b1;
            end
            tick("random");
        end

        for (int i = 0; i < 8; i++) begin
            randomize_inputs();
            bus.StallE   = 1'b0;
            bus.FlushE   = 1'b0;
            bus.PCD      = 32'(i * 4);
            bus.PCPlus4D = bus.PCD + 32'd4;
            tick("stream_state");
            chk("stream_pce", bus.PCE, 32'(i * 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
